// File: rtl/generator_seq.sv
// neuron_o: two-input fixed-point neuron, y = b + ((a_1*w_1 + a_2*w_2) >>> FRAC), wrapped to WIDTH.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module neuron_o #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] a_1,
  input  logic signed [WIDTH-1:0] a_2,
  input  logic signed [WIDTH-1:0] w_1,
  input  logic signed [WIDTH-1:0] w_2,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);
  localparam int AW = 2*WIDTH + 2;
  logic signed [AW-1:0] acc;

  // Full-precision sum of products, then drop the fraction bits and add the bias
  always_comb begin
    acc = AW'(a_1) * AW'(w_1) + AW'(a_2) * AW'(w_2);
    y   = b + WIDTH'(acc >>> FRAC);
  end
endmodule

// neuron_a: three-input fixed-point neuron with ReLU on the biased sum.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module neuron_a #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic signed [WIDTH-1:0] a_1,
  input  logic signed [WIDTH-1:0] a_2,
  input  logic signed [WIDTH-1:0] a_3,
  input  logic signed [WIDTH-1:0] w_1,
  input  logic signed [WIDTH-1:0] w_2,
  input  logic signed [WIDTH-1:0] w_3,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);
  localparam int AW = 2*WIDTH + 2;
  logic signed [AW-1:0]    acc;
  logic signed [WIDTH-1:0] sum;

  // Sum of products, scale back, add bias, clamp negatives to zero
  always_comb begin
    acc = AW'(a_1) * AW'(w_1) + AW'(a_2) * AW'(w_2) + AW'(a_3) * AW'(w_3);
    sum = b + WIDTH'(acc >>> FRAC);
    y   = sum[WIDTH-1] ? '0 : sum;
  end
endmodule

// generator_seq: 2-3-9 generator network evaluated one neuron per cycle on shared neurons.
// Latency: out_valid rises 12 cycles after the input accept edge; minimum initiation interval 14.
// Backpressure: the result frame is held in DONE until out_ready; no input is accepted meanwhile.
module generator_seq #(
  parameter int WIDTH       = 32,
  parameter int N_INPUT     = 2,
  parameter int N_NEURON_L2 = 3,
  parameter int N_NEURON_L3 = 9
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WIDTH-1:0]                       a_1,
  input  logic [WIDTH-1:0]                       a_2,
  input  logic [N_INPUT*N_NEURON_L2*WIDTH-1:0]   w_L2,
  input  logic [N_NEURON_L2*N_NEURON_L3*WIDTH-1:0] w_L3,
  input  logic [N_NEURON_L2*WIDTH-1:0]           b_L2,
  input  logic [N_NEURON_L3*WIDTH-1:0]           b_L3,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [N_NEURON_L3*WIDTH-1:0]           y,
  output logic                                   busy,
  output logic [3:0]                             idx
);
  typedef enum logic [1:0] {IDLE, L2, L3, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg  [2];
  logic [WIDTH-1:0] l2_reg [N_NEURON_L2];

  logic [1:0]       l2_sel;
  logic [3:0]       l3_sel;
  logic [WIDTH-1:0] l2_w1, l2_w2, l2_b, l2_out;
  logic [WIDTH-1:0] l3_w1, l3_w2, l3_w3, l3_b, l3_out;

  // Operand selection for the shared neurons; indices are clamped so the
  // slices stay in range whichever layer is active
  always_comb begin
    l2_sel = (idx > 4'd2) ? 2'd2 : idx[1:0];
    l3_sel = (idx > 4'd8) ? 4'd8 : idx;
    l2_w1  = w_L2[WIDTH*(2*l2_sel)     +: WIDTH];
    l2_w2  = w_L2[WIDTH*(2*l2_sel + 1) +: WIDTH];
    l2_b   = b_L2[WIDTH*l2_sel         +: WIDTH];
    l3_w1  = w_L3[WIDTH*(3*l3_sel)     +: WIDTH];
    l3_w2  = w_L3[WIDTH*(3*l3_sel + 1) +: WIDTH];
    l3_w3  = w_L3[WIDTH*(3*l3_sel + 2) +: WIDTH];
    l3_b   = b_L3[WIDTH*l3_sel         +: WIDTH];
  end

  neuron_o #(.WIDTH(WIDTH)) u_neuron_o (
    .a_1(a_reg[0]), .a_2(a_reg[1]),
    .w_1(l2_w1),    .w_2(l2_w2),
    .b(l2_b),       .y(l2_out)
  );

  neuron_a #(.WIDTH(WIDTH)) u_neuron_a (
    .a_1(l2_reg[0]), .a_2(l2_reg[1]), .a_3(l2_reg[2]),
    .w_1(l3_w1),     .w_2(l3_w2),     .w_3(l3_w3),
    .b(l3_b),        .y(l3_out)
  );

  // Sequencer: IDLE -> 3 layer-2 steps -> 9 layer-3 steps -> DONE, with registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      idx       <= '0;
      y         <= '0;
      a_reg[0]  <= '0;
      a_reg[1]  <= '0;
      for (int i = 0; i < N_NEURON_L2; i++) l2_reg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg[0] <= a_1;
            a_reg[1] <= a_2;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= L2;
          end
        end
        L2: begin
          l2_reg[l2_sel] <= l2_out;
          if (idx == 4'd2) begin
            idx   <= '0;
            state <= L3;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        L3: begin
          y[WIDTH*l3_sel +: WIDTH] <= l3_out;
          if (idx == 4'd8) begin
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_generator_seq.sv
// Scoreboard bench for generator_seq: expected frames pushed at issue, popped by a monitor on consumption.
// Reference model evaluates the 2-3-9 network with wide integer arithmetic.
// Covers reset, latency, sequencing, backpressure hold and back-to-back frames.
module tb_generator_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  a_1, a_2;
  logic [191:0]  w_L2;
  logic [863:0]  w_L3;
  logic [95:0]   b_L2;
  logic [287:0]  b_L3;
  logic          out_valid, out_ready;
  logic [287:0]  y;
  logic          busy;
  logic [3:0]    idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit b2b = 1'b0;
  logic [287:0] exp_q[$];
  int           acc_q[$];

  generator_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_1(a_1), .a_2(a_2),
    .w_L2(w_L2), .w_L3(w_L3), .b_L2(b_L2), .b_L3(b_L3),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy), .idx(idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic signed [127:0] mul(input int p, input int q);
    logic signed [127:0] pp = p;
    logic signed [127:0] qq = q;
    return pp * qq;
  endfunction

  // floor(s / 2^16), wrapped to 32 bits
  function automatic int fx(input logic signed [127:0] s);
    logic signed [127:0] t = s >>> 16;
    return int'(t[31:0]);
  endfunction

  function automatic logic [287:0] ref_frame(input int x1, input int x2);
    int h[3];
    int v;
    logic signed [127:0] s;
    logic [287:0] r = '0;
    for (int i = 0; i < 3; i++) begin
      s = mul(x1, w_L2[64*i +: 32]) + mul(x2, w_L2[64*i+32 +: 32]);
      h[i] = fx(s) + int'(b_L2[32*i +: 32]);
    end
    for (int j = 0; j < 9; j++) begin
      s = 0;
      for (int k = 0; k < 3; k++) s = s + mul(h[k], w_L3[32*(3*j+k) +: 32]);
      v = fx(s) + int'(b_L3[32*j +: 32]);
      r[32*j +: 32] = (v < 0) ? 32'd0 : v;
    end
    return r;
  endfunction

  task automatic rand_weights();
    for (int k = 0; k < 6; k++)  w_L2[32*k +: 32] = $urandom;
    for (int k = 0; k < 27; k++) w_L3[32*k +: 32] = $urandom;
    for (int k = 0; k < 3; k++)  b_L2[32*k +: 32] = $urandom;
    for (int k = 0; k < 9; k++)  b_L3[32*k +: 32] = $urandom;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int busy_cnt = 0;
    int n_b2b = 0;
    int last_acc = 0;
    int t;
    logic prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
        prev_ov  = 1'b0;
        exp_q.delete();
        acc_q.delete();
      end else begin
        if (!b2b) n_b2b = 0;
        if (in_valid && in_ready) begin
          acc_q.push_back(cyc + 1);
          if (b2b) begin
            if (n_b2b > 0) chk("accept_interval", cyc + 1 - last_acc, 14);
            n_b2b++;
          end
          last_acc = cyc + 1;
        end
        if (busy) begin
          chk("idx_seq", idx, (busy_cnt < 3) ? busy_cnt : busy_cnt - 3);
          busy_cnt++;
        end else begin
          chk("idx_idle", idx, 0);
        end
        if (out_valid && !prev_ov) begin
          chk("busy_len", busy_cnt, 12);
          busy_cnt = 0;
          if (acc_q.size() > 0) begin
            t = acc_q.pop_front();
            chk("latency", cyc - t, 12);
          end else begin
            chk("valid_without_accept", 1, 0);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
          else chk("frame_y", y, exp_q.pop_front());
        end
        prev_ov = out_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] x1, input logic [31:0] x2, input bit keep, input bit new_w);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1, 0);
      return;
    end
    if (new_w) rand_weights();
    a_1 = x1;
    a_2 = x2;
    exp_q.push_back(ref_frame(x1, x2));
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain(input bit rand_rdy);
    int n = 0;
    while ((exp_q.size() > 0 || !in_ready) && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (rand_rdy) out_ready = ($urandom % 2 == 1);
    end
    out_ready = 1'b1;
    chk("drain_done", (n < 80), 1);
  endtask

  initial begin : driver
    logic [287:0] held;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_1 = '0; a_2 = '0; w_L2 = '0; w_L3 = '0; b_L2 = '0; b_L3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", idx, 0);
    chk("rst_y", y, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single frame with the fixed input pair
    send(32'h0001_0000, 32'hFFFF_8000, 1'b0, 1'b1);
    drain(1'b0);

    // zero weights, layer-3 bias ramp
    rand_weights();
    w_L2 = '0;
    w_L3 = '0;
    for (int j = 0; j < 9; j++) b_L3[32*j +: 32] = j * 32'h0000_1000;
    send($urandom, $urandom, 1'b0, 1'b0);
    drain(1'b0);
    for (int j = 0; j < 9; j++) chk("zero_w_slice", y[32*j +: 32], j * 32'h0000_1000);

    // random frames with random consumer readiness
    for (int f = 0; f < 6; f++) begin
      send($urandom, $urandom, 1'b0, 1'b1);
      drain(1'b1);
    end

    // backpressure hold
    out_ready = 1'b0;
    send($urandom, $urandom, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_valid_seen", out_valid, 1);
    held = y;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 0);
      a_1 = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_y", y, held);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_one_frame_valid", out_valid, 0);
    chk("hold_queue_empty", exp_q.size(), 0);

    // back-to-back frames
    b2b = 1'b1;
    for (int f = 0; f < 5; f++) send($urandom, $urandom, (f < 4), 1'b1);
    drain(1'b0);
    b2b = 1'b0;

    // reset in the middle of layer 3
    send($urandom, $urandom, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y", y, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send($urandom, $urandom, 1'b0, 1'b1);
    drain(1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/generator_seq.md
# generator_seq

Time-multiplexed controller for the 2-3-9 generator network. It accepts one input pair per transaction over a valid/ready handshake and reuses a single `neuron_o` instance and a single `neuron_a` instance. It steps through the 3 layer-2 neurons and then the 9 layer-3 neurons, one neuron per cycle. It returns the 9 results as a packed frame over a second valid/ready handshake, and is the area-reduced alternative to the fully parallel `generator`.

## Interface
- `WIDTH`, 32: data word width, signed, same fixed-point format as `neuron_o`/`neuron_a`.
- `N_INPUT`, 2: layer-1 inputs. Fixed; other values are unsupported.
- `N_NEURON_L2`, 3: layer-2 neurons. Fixed.
- `N_NEURON_L3`, 9: layer-3 neurons. Fixed.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: input pair valid.
- `in_ready` out 1: block can accept. High only in IDLE.
- `a_1`, `a_2` in WIDTH each: signed inputs. Captured on input handshake.
- `w_L2` in N_INPUT*N_NEURON_L2*WIDTH: layer-2 weights. Same packing as `generator`: neuron i's w_1 is at slice 2i, w_2 at slice 2i+1.
- `w_L3` in N_NEURON_L2*N_NEURON_L3*WIDTH: layer-3 weights. Neuron j's w_k is at slice 3j+k-1.
- `b_L2` in N_NEURON_L2*WIDTH, `b_L3` in N_NEURON_L3*WIDTH: biases. Neuron i/j uses slice i/j.
- `out_valid` out 1: result frame valid.
- `out_ready` in 1: consumer accepts the frame.
- `y` out N_NEURON_L3*WIDTH: results. Slice j = neuron j; j=0 is y_1x1, j=8 is y_3x3.
- `busy` out 1: high in L2 and L3 states.
- `idx` out 4: current neuron index, for debug.

## Operation
- States: IDLE, L2, L3, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `a_1`/`a_2` into `a_reg`, clear `idx` to 0, and go to L2.
- L2: the shared `neuron_o` gets `a_reg`, weight slices 2·idx and 2·idx+1 of `w_L2`, and bias slice idx of `b_L2`.
  - Each edge writes the neuron output into `l2_reg[idx]` and increments `idx`.
  - After idx=2 is written, clear `idx` to 0 and go to L3.
- L3: the shared `neuron_a` gets `l2_reg[0..2]`, weight slices 3·idx..3·idx+2 of `w_L3`, and bias slice idx of `b_L3`.
  - Each edge writes the result into `y` slice idx and increments `idx`.
  - After idx=8 is written, go to DONE.
- DONE: `out_valid`=1 and `y` is held stable. On `out_ready`, go to IDLE. `y` keeps its last value.
- Weights and biases are not captured. The source must hold them stable from acceptance until `out_valid` rises. Changing them mid-frame corrupts only the neurons evaluated after the change.
- `in_valid` outside IDLE is ignored; no input is queued.
- Arithmetic is entirely inside `neuron_o`/`neuron_a`; the block adds no rounding or saturation. Results are bit-identical to `generator` for identical inputs.
- `idx` is 0 in IDLE and DONE. It never exceeds 2 in L2 or 8 in L3.

## Timing
- Reset (async assert): state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `idx`=0, `y`=0, `l2_reg`=0, `a_reg`=0.
- Reset mid-frame abandons the frame with no output.
- Call the accept edge E0.
  - L2 writes occur at E1–E3 and L3 writes at E4–E12.
  - `out_valid` rises after E12: latency is 12 cycles.
  - `busy` is high from after E0 until after E12.
- `out_ready` already high when `out_valid` rises: the frame is consumed at E13 and `in_ready` is 1 after E13.
  - The earliest next accept is E14, so the minimum initiation interval is 14 cycles.
- `out_ready` held low: DONE persists indefinitely with `y` and `out_valid` stable.
- `in_ready` is a registered function of the state only. It does not depend combinationally on `in_valid` or `out_ready`.

## Test plan
- Reset: assert `rst_n`=0 mid-L3 (e.g. 7 cycles after accept) → next cycle `out_valid`=0, `y`=0, `in_ready`=1. The next accepted frame completes normally.
- Single frame: `a_1`=32'h0001_0000, `a_2`=32'hFFFF_8000, random weights and biases → `out_valid` 12 cycles after accept. `y` bit-equal to a parallel `generator` instance driven with the same values.
- Zero weights: all weights 0, `b_L3` slice j = j·32'h0000_1000 → each `y` slice j equals the `neuron_a` output for inputs 0 and bias j·32'h0000_1000, matching `generator`.
- Backpressure: hold `out_ready`=0 for 20 cycles → `out_valid` and `y` constant throughout. `in_valid` pulses during the hold are ignored (`in_ready`=0). Release gives exactly one frame.
- Back-to-back: `in_valid` and `out_ready` held at 1 for 5 frames with distinct inputs → accepts exactly 14 cycles apart. Frames arrive in order and each matches `generator`.
- Sequencing check: monitor `idx` → it counts 0,1,2 in L2, then 0..8 in L3. `busy` is high for exactly 12 cycles per frame.
